// File: rtl/fbuf_arbiter.sv
// fbuf_arbiter: display/clear/CPU slot arbiter for the 512x16 framebuffer RAM; hardware clear engine enabled by FBUF_HW_CLEAR_EN
`timescale 1ns/1ps
module fbuf_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int CLR_WORDS = 512
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1
`ifdef FBUF_HW_CLEAR_EN
    , CLEAR = 2'd2
`endif
  } state_t;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_WORDS - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic clr_take, clr_g, disp_g, cpu_g, cpu_wr, rd_vld, rd_tag, rd_ack;
  // grants are gated by res_n so every output reads 0 while reset is held
  assign disp_g = res_n & disp_req;
  assign cpu_g  = res_n & ~disp_req & ~clr_take & (state == IDLE) & cpu_req;
  assign cpu_wr = cpu_g & cpu_we;
`ifdef FBUF_HW_CLEAR_EN
  logic clr_pend;
  assign clr_take = (state == IDLE) & (clr_start | clr_pend);
  assign clr_g    = res_n & ~disp_req & (state == CLEAR);
  assign clr_busy = state == CLEAR;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      clr_addr <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (clr_g) clr_addr <= (clr_addr == CLR_LAST) ? '0 : clr_addr + ADDR_W'(1);
      clr_pend <= (state == CPU_RD) ? (clr_pend | clr_start) : 1'b0;
    end
`else
  logic unused_clr;
  assign unused_clr = clr_start | ^CLR_LAST;
  assign clr_take   = 1'b0;
  assign clr_g      = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_addr   = '0;
`endif
  always_comb begin
    ram_addr  = disp_g ? disp_addr : clr_g ? clr_addr : cpu_g ? cpu_addr : '0;
    ram_we    = clr_g | cpu_wr;
    ram_wdata = cpu_wr ? cpu_wdata : '0;
  end
  assign cpu_ack = cpu_wr | rd_ack;
  always_comb begin
    state_nx = state;
    if (cpu_g && !cpu_we) state_nx = CPU_RD;
    if (state == CPU_RD && rd_ack) state_nx = IDLE;
`ifdef FBUF_HW_CLEAR_EN
    if (clr_take) state_nx = CLEAR;
    if (clr_g && clr_addr == CLR_LAST) state_nx = IDLE;
`endif
  end
  // read pipe: rd_tag=1 marks a CPU read, 0 a display read
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state      <= IDLE;
      rd_vld     <= 1'b0;
      rd_tag     <= 1'b0;
      rd_ack     <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_nx;
      rd_vld     <= disp_g | (cpu_g & ~cpu_we);
      rd_tag     <= ~disp_g;
      disp_valid <= rd_vld & ~rd_tag;
      rd_ack     <= rd_vld & rd_tag;
      if (rd_vld && !rd_tag) disp_data <= ram_rdata;
      if (rd_vld && rd_tag) cpu_rdata <= ram_rdata;
    end
endmodule

// File: tb/tb_fbuf_arbiter.sv
// tb_fbuf_arbiter: scoreboard bench for fbuf_arbiter with a synchronous 512x16 RAM model
`timescale 1ns/1ps
module tb_fbuf_arbiter;
  logic clk = 1'b0, res_n = 1'b0;
  logic disp_req = 1'b0, disp_valid, cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic clr_start = 1'b0, clr_busy, ram_we;
  logic [8:0] disp_addr = '0, cpu_addr = '0, ram_addr;
  logic [15:0] disp_data, cpu_wdata = '0, cpu_rdata, ram_wdata, ram_rdata;
  logic [15:0] mem [512];
  logic [15:0] ref_mem [512];
  logic pre_we = 1'b0;
  logic [8:0] pre_a = '0;
  logic [15:0] pre_d = '0;
  typedef struct { int c; logic [15:0] d; bit rd; } exp_t;
  exp_t dq[$];
  exp_t cq[$];
  int cyc = 0, n_chk = 0, n_err = 0;
  bit cpu_done = 1'b0;

  fbuf_arbiter dut (
    .clk(clk), .res_n(res_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_a] <= pre_d;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {3'b0, disp_data, disp_valid, cpu_rdata, cpu_ack, clr_busy, ram_addr, ram_we, ram_wdata};
  endfunction

  task automatic cpu_go(input logic we, input logic [8:0] a, input logic [15:0] d, input int ack_c);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (ack_c >= 0) cq.push_back('{ack_c, we ? 16'h0 : ref_mem[a], !we});
  endtask

  task automatic tick(input logic dr, input logic [8:0] da, input logic cs);
    exp_t e;
    disp_req = dr; disp_addr = da; clr_start = cs;
    if (dr) dq.push_back('{cyc + 2, ref_mem[da], 1'b1});
    @(negedge clk);
    while (dq.size() > 0 && dq[0].c < cyc) begin
      chk("disp_missing", 64'(cyc), 64'(dq[0].c));
      e = dq.pop_front();
    end
    if (disp_valid) begin
      if (dq.size() == 0) chk("disp_spurious", 64'(disp_valid), 64'd0);
      else begin
        e = dq.pop_front();
        chk("disp_cycle", 64'(cyc), 64'(e.c));
        chk("disp_data", 64'(disp_data), 64'(e.d));
      end
    end
    while (cq.size() > 0 && cq[0].c < cyc) begin
      chk("cpu_missing", 64'(cyc), 64'(cq[0].c));
      e = cq.pop_front();
    end
    if (cpu_ack) begin
      if (cq.size() == 0) chk("cpu_spurious", 64'(cpu_ack), 64'd0);
      else begin
        e = cq.pop_front();
        chk("cpu_cycle", 64'(cyc), 64'(e.c));
        if (e.rd) chk("cpu_rdata", 64'(cpu_rdata), 64'(e.d));
        else ref_mem[cpu_addr] = cpu_wdata;
      end
      cpu_done = 1'b1;
    end
    @(posedge clk); #1;
    if (cpu_done) begin
      cpu_req = 1'b0;
      cpu_done = 1'b0;
    end
  endtask

  initial begin
    int busy_n, dcnt, k, nz;
    @(posedge clk); #1;
    pre_we = 1'b1;
    for (int i = 0; i < 512; i++) begin
      pre_a = 9'(i);
      pre_d = (i == 5) ? 16'hA5A5 : (i == 7) ? 16'h1234 : (16'(i) * 16'h0101) ^ 16'h3C5A;
      ref_mem[i] = pre_d;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    disp_req = 1'b1; disp_addr = 9'd5; cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 16'hFFFF; clr_start = 1'b1;
    #1;
    chk("reset_outputs", outs(), 64'd0);
    disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; clr_start = 1'b0;
    res_n = 1'b1;
    tick(0, 0, 0);
    // single display read, then held data
    tick(1, 9'd5, 0);
    repeat (3) tick(0, 0, 0);
    chk("disp_hold", 64'(disp_data), 64'h0000_0000_0000_A5A5);
    chk("disp_valid_low", 64'(disp_valid), 64'd0);
    for (int i = 0; i < 8; i++) tick(1, 9'(500 + i * 2), 0);
    repeat (3) tick(0, 0, 0);
    // CPU read starved by display for three cycles
    cpu_go(0, 9'd7, 16'h0, cyc + 5);
    tick(1, 9'd40, 0); tick(1, 9'd41, 0); tick(1, 9'd42, 0);
    repeat (4) tick(0, 0, 0);
    // CPU write acked in its grant cycle, then read back by the display
    cpu_go(1, 9'd3, 16'hFFFF, cyc);
    tick(0, 0, 0);
    tick(1, 9'd3, 0);
    repeat (3) tick(0, 0, 0);
    cpu_go(1, 9'h1FF, 16'h0F0F, cyc + 2);
    tick(1, 9'd3, 0); tick(1, 9'd3, 0);
    tick(0, 0, 0); tick(1, 9'h1FF, 0);
    repeat (3) tick(0, 0, 0);
    // back-to-back CPU reads
    cpu_go(0, 9'd7, 16'h0, cyc + 2);
    repeat (3) tick(0, 0, 0);
    cpu_go(0, 9'd3, 16'h0, cyc + 2);
    repeat (4) tick(0, 0, 0);
    // reset while a CPU read is outstanding
    cpu_go(0, 9'd7, 16'h0, -1);
    tick(0, 0, 0);
    res_n = 1'b0; disp_req = 1'b1; disp_addr = 9'd5;
    #1;
    chk("rst_mid_read", outs(), 64'd0);
    repeat (3) tick(0, 0, 0);
    cpu_req = 1'b0;
    res_n = 1'b1;
    repeat (2) tick(0, 0, 0);
`ifdef FBUF_HW_CLEAR_EN
    // clr_start during CPU_RD is deferred until the read completes
    cpu_go(0, 9'd7, 16'h0, cyc + 2);
    tick(0, 0, 0); tick(0, 0, 1); tick(0, 0, 0);
    chk("clr_pend_wait", 64'(clr_busy), 64'd0);
    tick(0, 0, 0);
    chk("clr_pend_busy", 64'(clr_busy), 64'd1);
    repeat (100) tick(0, 0, 0);
    res_n = 1'b0; disp_req = 1'b1; disp_addr = 9'd5;
    #1;
    chk("rst_mid_clear", outs(), 64'd0);
    disp_req = 1'b0;
    @(posedge clk); #1;
    res_n = 1'b1;
    tick(0, 0, 0);
    // full clear with 50% display traffic and a waiting CPU write
    chk("clr_idle", 64'(clr_busy), 64'd0);
    tick(0, 0, 1);
    clr_start = 1'b0;
    #1;
    chk("clr_restart_addr", {54'd0, ram_we, ram_addr}, {54'd0, 1'b1, 9'd0});
    cpu_go(1, 9'd100, 16'hBEEF, -1);
    busy_n = 0; dcnt = 0; k = 0;
    while (clr_busy && k < 3000) begin
      tick((k % 2) == 1, 9'd511, k == 10);
      busy_n++;
      if ((k % 2) == 1) dcnt++;
      k++;
    end
    chk("clr_busy_len", 64'(busy_n), 64'(512 + dcnt));
    for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0;
    cq.push_back('{cyc, 16'h0, 1'b0});
    repeat (3) tick(0, 0, 0);
    nz = 0;
    for (int i = 0; i < 512; i++) if (i != 100 && mem[i] !== 16'h0) nz++;
    chk("clr_ram_zero", 64'(nz), 64'd0);
    chk("cpu_wr_after_clr", 64'(mem[100]), 64'h0000_0000_0000_BEEF);
    tick(1, 9'd0, 0); tick(1, 9'd5, 0); tick(1, 9'd511, 0); tick(1, 9'd100, 0);
`else
    // without the clear engine clr_start is ignored
    cpu_go(1, 9'd20, 16'h5555, cyc);
    tick(0, 0, 1);
    chk("no_clr_busy", 64'(clr_busy), 64'd0);
    repeat (2) tick(0, 0, 0);
    tick(1, 9'd20, 0);
`endif
    repeat (4) tick(0, 0, 0);
    chk("disp_queue_empty", 64'(dq.size()), 64'd0);
    chk("cpu_queue_empty", 64'(cq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
